// File: rtl/pp_issue_if.sv
// Handshake bundle between the BCD multiplier issue controller and its surroundings:
// operand input, partial-product stream to the accumulator, accumulator result and product output.
interface pp_issue_if #(parameter int PP_W = 44);
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     X_BCD;
    logic [15:0]     Y_BCD;
    logic            acc_clear;
    logic [PP_W-1:0] pp_data;
    logic [2:0]      pp_idx;
    logic            pp_last;
    logic            pp_valid;
    logic            pp_ready;
    logic            acc_done;
    logic [31:0]     acc_sum;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_bcd;
    logic [1:0]      res_err;
    logic            busy;

    modport master (
        input  in_valid, X_BCD, Y_BCD, pp_ready, acc_done, acc_sum, res_ready,
        output in_ready, acc_clear, pp_data, pp_idx, pp_last, pp_valid,
               res_valid, res_bcd, res_err, busy
    );

    modport slave (
        output in_valid, X_BCD, Y_BCD, pp_ready, acc_done, acc_sum, res_ready,
        input  in_ready, acc_clear, pp_data, pp_idx, pp_last, pp_valid,
               res_valid, res_bcd, res_err, busy
    );
endinterface

// File: rtl/pp_issue_controller.sv
// Issue controller for the 4-digit BCD multiplier: registers operands, builds five signed-digit
// partial products, streams them to the decimal accumulator and returns the 8-digit product.
module pp_issue_controller #(
    parameter int NUM_PP  = 5,
    parameter int PP_W    = 44,
    parameter int TIMEOUT = 64
) (
    input logic        clk,
    input logic        rst,
    pp_issue_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_ACC, DONE} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state, next_state;
    logic [15:0]     x_reg, y_reg;
    logic [PP_W-1:0] bank   [NUM_PP];
    logic [PP_W-1:0] gen_pp [NUM_PP];
    logic [2:0]      idx;
    logic [CW-1:0]   tcnt;
    logic [31:0]     res_bcd_q;
    logic [1:0]      res_err_q;
    logic            operands_ok;
    logic            last_fire;
    logic            timed_out;

    function automatic logic bcd_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Y is recoded to signed digits in -4..5 (digit 4 is the final carry), so each PP is
    // X*|d| shifted by pos digits, ten's-complemented over all 11 digits when d is negative.
    function automatic logic [PP_W-1:0] make_pp(input logic [15:0] x, input logic [15:0] y,
                                                input int pos);
        logic [PP_W-1:0] r;
        logic [19:0]     ye;
        logic            neg;
        int              c, d, mag, p;
        ye = {4'd0, y};
        c  = 0;
        d  = 0;
        for (int k = 0; k <= pos; k++) begin
            d = int'(ye[4*k +: 4]) + c;
            if (d >= 6) begin
                d = d - 10;
                c = 1;
            end else begin
                c = 0;
            end
        end
        neg = (d < 0);
        mag = neg ? -d : d;
        r   = '0;
        c   = 0;
        for (int j = 0; j < 4; j++) begin
            p = int'(x[4*j +: 4]) * mag + c;
            r[4*(j+pos) +: 4] = 4'(p % 10);
            c = p / 10;
        end
        r[4*(4+pos) +: 4] = 4'(c);
        if (neg) begin
            c = 1;
            for (int k = 0; k < PP_W/4; k++) begin
                p = 9 - int'(r[4*k +: 4]) + c;
                if (p == 10) begin
                    r[4*k +: 4] = 4'd0;
                    c = 1;
                end else begin
                    r[4*k +: 4] = 4'(p);
                    c = 0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PP; i++)
            gen_pp[i] = make_pp(x_reg, y_reg, i);
    end

    assign operands_ok = bcd_ok(bus.X_BCD) && bcd_ok(bus.Y_BCD);
    assign last_fire   = bus.pp_ready && (idx == 3'(NUM_PP - 1));
    assign timed_out   = (tcnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.acc_clear = 1'b0;
        bus.pp_valid  = 1'b0;
        bus.pp_data   = '0;
        bus.pp_idx    = '0;
        bus.pp_last   = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_bcd   = res_bcd_q;
        bus.res_err   = res_err_q;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) next_state = operands_ok ? LOAD : DONE;
            end
            LOAD: begin
                bus.acc_clear = 1'b1;
                next_state    = ISSUE;
            end
            ISSUE: begin
                bus.pp_valid = 1'b1;
                bus.pp_data  = bank[idx];
                bus.pp_idx   = idx;
                bus.pp_last  = (idx == 3'(NUM_PP - 1));
                if (last_fire) next_state = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (bus.acc_done || timed_out) next_state = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers; acc_done wins over the final timeout count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            idx       <= '0;
            tcnt      <= '0;
            res_bcd_q <= '0;
            res_err_q <= 2'b00;
            for (int i = 0; i < NUM_PP; i++) bank[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_reg     <= bus.X_BCD;
                        y_reg     <= bus.Y_BCD;
                        res_bcd_q <= '0;
                        res_err_q <= operands_ok ? 2'b00 : 2'b01;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < NUM_PP; i++) bank[i] <= gen_pp[i];
                    idx <= '0;
                end
                ISSUE: begin
                    if (bus.pp_ready) begin
                        idx <= last_fire ? 3'd0 : idx + 3'd1;
                        if (last_fire) tcnt <= '0;
                    end
                end
                WAIT_ACC: begin
                    tcnt <= tcnt + 1'b1;
                    if (bus.acc_done) begin
                        res_bcd_q <= bus.acc_sum;
                        res_err_q <= 2'b00;
                    end else if (timed_out) begin
                        res_bcd_q <= '0;
                        res_err_q <= 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pp_issue_controller.sv
// Randomized self-checking bench for pp_issue_controller; the bench also plays the decimal
// accumulator, summing received partial products as plain integers modulo 10^11.
module tb_pp_issue_controller;
    localparam int     TO  = 8;
    localparam longint P11 = 64'd100_000_000_000;
    localparam longint P8  = 64'd100_000_000;

    logic clk = 1'b0;
    logic rst;
    int   testCount = 0;
    int   failCount = 0;

    pp_issue_if bus ();

    pp_issue_controller #(.NUM_PP(5), .PP_W(44), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic longint pow10(input int n);
        longint v = 1;
        for (int i = 0; i < n; i++) v = v * 10;
        return v;
    endfunction

    function automatic longint fromBcd(input logic [63:0] b, input int nd);
        longint v = 0;
        for (int i = nd - 1; i >= 0; i--) v = v * 10 + longint'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [63:0] toBcd(input longint v, input int nd);
        logic [63:0] r = '0;
        longint      t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit digitsOk(input logic [15:0] v);
        bit ok = 1'b1;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Partial product i = X * d_i * 10^i, d_i the signed recoded digit of Y, as 11-digit ten's complement.
    function automatic logic [43:0] modelPp(input logic [15:0] x, input logic [15:0] y, input int i);
        longint xv = fromBcd(64'(x), 4);
        longint yv = fromBcd(64'(y), 4);
        longint v;
        int     c = 0;
        int     d = 0;
        for (int k = 0; k <= i; k++) begin
            d = int'((yv / pow10(k)) % 10) + c;
            if (d >= 6) begin
                d = d - 10;
                c = 1;
            end else begin
                c = 0;
            end
        end
        v = xv * longint'(d) * pow10(i);
        if (v < 0) v = v + P11;
        return 44'(toBcd(v, 11));
    endfunction

    function automatic logic [15:0] randBcd(input bit allowBad);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allowBad && $urandom_range(0, 7) == 0) r[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input int stallMode,
                                 input int accDelay, input int resHold, input bit stray,
                                 input int abortIdx);
        int          ph, hs, waitCnt, doneCnt, issueCyc;
        bit          done, rdy;
        longint      accum;
        logic [31:0] expProd, expRes;
        logic [1:0]  expErr;

        @(negedge clk);
        checkOutput("in_ready_idle", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.X_BCD    = x;
        bus.Y_BCD    = y;
        expProd  = 32'(toBcd(fromBcd(64'(x), 4) * fromBcd(64'(y), 4), 8));
        ph       = (digitsOk(x) && digitsOk(y)) ? 1 : 4;
        expRes   = '0;
        expErr   = (ph == 1) ? 2'b00 : 2'b01;
        hs       = 0;
        waitCnt  = 0;
        doneCnt  = 0;
        issueCyc = 0;
        accum    = 0;
        done     = 1'b0;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            checkOutput("busy", 64'(bus.busy), 64'(1));
            checkOutput("in_ready_busy", 64'(bus.in_ready), 64'(0));
            checkOutput("acc_clear", 64'(bus.acc_clear), 64'(ph == 1));
            checkOutput("pp_valid", 64'(bus.pp_valid), 64'(ph == 2));
            checkOutput("res_valid", 64'(bus.res_valid), 64'(ph == 4));
            if (ph == 2) begin
                checkOutput("pp_idx", 64'(bus.pp_idx), 64'(hs));
                checkOutput("pp_data", 64'(bus.pp_data), 64'(modelPp(x, y, hs)));
                checkOutput("pp_last", 64'(bus.pp_last), 64'(hs == 4));
                if (hs == abortIdx) begin
                    #2 rst = 1'b1;
                    #1;
                    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
                    checkOutput("rst_pp_valid", 64'(bus.pp_valid), 64'(0));
                    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
                    bus.pp_ready = 1'b0;
                    bus.acc_done = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    @(negedge clk);
                    checkOutput("post_rst_pp_valid", 64'(bus.pp_valid), 64'(0));
                    checkOutput("post_rst_res_valid", 64'(bus.res_valid), 64'(0));
                    return;
                end
            end
            if (ph == 4) begin
                checkOutput("res_bcd", 64'(bus.res_bcd), 64'(expRes));
                checkOutput("res_err", 64'(bus.res_err), 64'(expErr));
            end

            case (stallMode)
                0:       rdy = 1'b1;
                1:       rdy = (issueCyc % 3 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            bus.pp_ready = rdy;
            bus.acc_done = 1'b0;
            bus.acc_sum  = $urandom;
            if (ph == 3 && waitCnt == accDelay) begin
                bus.acc_done = 1'b1;
                bus.acc_sum  = 32'(toBcd(accum % P8, 8));
            end else if (ph != 3 && stray && $urandom_range(0, 1) == 1) begin
                bus.acc_done = 1'b1;
            end
            bus.res_ready = (ph == 4 && doneCnt >= resHold);
            if (ph == 4 && !bus.res_ready) begin
                bus.in_valid = 1'b1;
                bus.X_BCD    = 16'($urandom);
                bus.Y_BCD    = 16'($urandom);
            end

            case (ph)
                1: ph = 2;
                2: begin
                    issueCyc++;
                    if (rdy) begin
                        accum = (accum + fromBcd(64'(bus.pp_data), 11)) % P11;
                        hs++;
                        if (hs == 5) begin
                            ph      = 3;
                            waitCnt = 0;
                        end
                    end
                end
                3: begin
                    if (bus.acc_done) begin
                        ph     = 4;
                        expRes = expProd;
                        expErr = 2'b00;
                    end else if (waitCnt == TO - 1) begin
                        ph     = 4;
                        expRes = '0;
                        expErr = 2'b10;
                    end else begin
                        waitCnt++;
                    end
                end
                default: begin
                    if (bus.res_ready) done = 1'b1;
                    else doneCnt++;
                end
            endcase
        end
        if (!done) checkOutput("op_cycle_budget", 64'(0), 64'(1));

        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.pp_ready  = 1'b0;
        bus.acc_done  = 1'b0;
        checkOutput("in_ready_after", 64'(bus.in_ready), 64'(1));
        checkOutput("res_valid_after", 64'(bus.res_valid), 64'(0));
        checkOutput("busy_after", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.X_BCD     = '0;
        bus.Y_BCD     = '0;
        bus.pp_ready  = 1'b0;
        bus.acc_done  = 1'b0;
        bus.acc_sum   = '0;
        bus.res_ready = 1'b0;
        #12;
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("reset_busy", 64'(bus.busy), 64'(0));
        checkOutput("reset_pp_valid", 64'(bus.pp_valid), 64'(0));
        checkOutput("reset_res_valid", 64'(bus.res_valid), 64'(0));
        checkOutput("reset_acc_clear", 64'(bus.acc_clear), 64'(0));
        checkOutput("reset_res_bcd", 64'(bus.res_bcd), 64'(0));
        checkOutput("reset_res_err", 64'(bus.res_err), 64'(0));
        checkOutput("reset_pp_idx", 64'(bus.pp_idx), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(16'h1234, 16'h5678, 0, 0, 0, 1'b0, -1);
        applyStimulus(16'h9999, 16'h9999, 1, 0, 0, 1'b0, -1);
        applyStimulus(16'h12A4, 16'h1111, 0, 0, 0, 1'b0, -1);
        applyStimulus(16'h4321, 16'h8765, 0, -1, 0, 1'b1, -1);
        applyStimulus(16'h5555, 16'h0005, 0, 0, 0, 1'b0, 2);
        applyStimulus(16'h0001, 16'h0001, 0, 0, 0, 1'b0, -1);
        applyStimulus(16'h2468, 16'h1357, 0, 0, 10, 1'b0, -1);
        applyStimulus(16'h9876, 16'h5432, 0, TO - 1, 0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(randBcd(1'b1), randBcd(1'b1), 2,
                          int'($urandom_range(0, TO)) - 1, int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
